// File: rtl/buffer_port_arbiter.sv
// buffer_port_arbiter
// Round-robin sharing of one BRAM buffer port between NREQ requesters.
// The winning request is registered onto the buffer port, and a small
// {valid, id} pipeline routes the read data back to the requester that
// issued the read, READ_LATENCY cycles after the en_o cycle.
module buffer_port_arbiter #(
   parameter int NREQ         = 4,
   parameter int READ_LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_i,
   input  logic [NREQ*4-1:0]    we_ib,
   input  logic [NREQ*32-1:0]   addr_ib,
   input  logic [NREQ*32-1:0]   din_ib,
   output logic [NREQ-1:0]      gnt_o,
   output logic [NREQ-1:0]      rvalid_o,
   output logic [31:0]          dout_ob,
   output logic                 en_o,
   output logic [3:0]           we_ob,
   output logic [31:0]          addr_ob,
   output logic [31:0]          din_ob,
   input  logic [31:0]          dout_ib
);

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef struct packed {
      logic           valid;
      logic [IDW-1:0] id;
   } trk_t;

   logic [IDW-1:0] last_q;
   logic [NREQ-1:0] eligible;
   logic            win_found;
   logic [IDW-1:0]  win_id;
   trk_t            trk_q [READ_LATENCY];

   // Winner search: first eligible index at or after last_q+1, wrapping.
   // NOTE: every variable gets a default before the loop so no path leaves it unassigned, which would infer a latch.
   always_comb begin
      int             cand;
      logic [IDW-1:0] cand_id;
      eligible  = req_i & ~gnt_o;
      win_found = 1'b0;
      win_id    = '0;
      cand      = 0;
      cand_id   = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = int'(last_q) + 1 + i;
         if (cand >= NREQ) cand -= NREQ;
         cand_id = IDW'(cand);
         if (!win_found && eligible[cand_id]) begin
            win_found = 1'b1;
            win_id    = cand_id;
         end
      end
   end

   // Register the winning access onto the buffer port and remember the winner.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         en_o    <= 1'b0;
         we_ob   <= '0;
         addr_ob <= '0;
         din_ob  <= '0;
         gnt_o   <= '0;
         last_q  <= IDW'(NREQ - 1);
      end else begin
         en_o  <= win_found;
         gnt_o <= '0;
         if (win_found) begin
            gnt_o[win_id] <= 1'b1;
            we_ob         <= we_ib[int'(win_id)*4 +: 4];
            addr_ob       <= addr_ib[int'(win_id)*32 +: 32];
            din_ob        <= din_ib[int'(win_id)*32 +: 32];
            last_q        <= win_id;
         end
      end
   end

   // Read tracker: one entry per issued read, shifted once per cycle.
   // In an en_o cycle last_q already holds the id of the access on the port.
   // NOTE: this small pipeline is explicitly reset so reads in flight at reset never raise rvalid.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < READ_LATENCY; i++) trk_q[i] <= '0;
      end else begin
         trk_q[0].valid <= en_o && (we_ob == 4'h0);
         trk_q[0].id    <= last_q;
         for (int i = 1; i < READ_LATENCY; i++) trk_q[i] <= trk_q[i-1];
      end
   end

   // Decode the tracker output into a one-hot read-valid pulse.
   always_comb begin
      rvalid_o = '0;
      if (trk_q[READ_LATENCY-1].valid) rvalid_o[trk_q[READ_LATENCY-1].id] = 1'b1;
   end

   assign dout_ob = dout_ib;

endmodule

// File: tb/tb_buffer_port_arbiter.sv
// tb_buffer_port_arbiter
// Directed stimulus with a scoreboard: tests push expected grants, a
// negedge monitor pops them on each gnt_o and schedules the expected
// read return, then checks every rvalid_o against that schedule.
module tb_buffer_port_arbiter;

   localparam int NREQ = 4;
   localparam int L    = 2;

   typedef struct {
      int          id;
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] din;
      logic [31:0] rdata;
   } gexp_t;

   typedef struct {
      int          id;
      logic [31:0] data;
      int          due;
   } rexp_t;

   logic                clk;
   logic                reset;
   logic [NREQ-1:0]     req_i;
   logic [NREQ*4-1:0]   we_ib;
   logic [NREQ*32-1:0]  addr_ib;
   logic [NREQ*32-1:0]  din_ib;
   logic [NREQ-1:0]     gnt_o;
   logic [NREQ-1:0]     rvalid_o;
   logic [31:0]         dout_ob;
   logic                en_o;
   logic [3:0]          we_ob;
   logic [31:0]         addr_ob;
   logic [31:0]         din_ob;
   logic [31:0]         dout_ib;

   logic                req_r  [NREQ];
   logic [3:0]          we_r   [NREQ];
   logic [31:0]         addr_r [NREQ];
   logic [31:0]         din_r  [NREQ];

   gexp_t gq [$];
   rexp_t rq [$];
   int    cyc = 0;
   int    n_cmp = 0;
   int    n_fail = 0;

   logic [31:0] mem [64];
   logic [31:0] rd0, rd1;

   buffer_port_arbiter #(.NREQ(NREQ), .READ_LATENCY(L)) dut (
      .clk(clk), .reset(reset), .req_i(req_i), .we_ib(we_ib),
      .addr_ib(addr_ib), .din_ib(din_ib), .gnt_o(gnt_o),
      .rvalid_o(rvalid_o), .dout_ob(dout_ob), .en_o(en_o),
      .we_ob(we_ob), .addr_ob(addr_ob), .din_ob(din_ob), .dout_ib(dout_ib)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Pack per-requester stimulus into the flat buses.
   always_comb begin
      req_i = '0; we_ib = '0; addr_ib = '0; din_ib = '0;
      for (int k = 0; k < NREQ; k++) begin
         req_i[k]           = req_r[k];
         we_ib[k*4 +: 4]    = we_r[k];
         addr_ib[k*32 +: 32] = addr_r[k];
         din_ib[k*32 +: 32]  = din_r[k];
      end
   end

   // BRAM model with two-cycle read latency and byte write enables.
   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[0] = 32'h11111111;
      mem[1] = 32'h22222222;
      mem[2] = 32'h33333333;
      mem[3] = 32'h44444444;
   end

   always @(posedge clk) begin
      if (en_o) begin
         if (we_ob != 4'h0) begin
            for (int b = 0; b < 4; b++)
               if (we_ob[b]) mem[addr_ob[7:2]][b*8 +: 8] <= din_ob[b*8 +: 8];
         end else begin
            rd0 <= mem[addr_ob[7:2]];
         end
      end
      rd1 <= rd0;
   end
   assign dout_ib = rd1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic report(input string name, input string what);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
   endtask

   task automatic push_exp(input int id, input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] din, input logic [31:0] rdata);
      gexp_t g;
      g.id = id; g.we = we; g.addr = addr; g.din = din; g.rdata = rdata;
      gq.push_back(g);
   endtask

   // Scoreboard monitor, sampling away from the active edge.
   always @(negedge clk) begin
      gexp_t g;
      rexp_t r;
      if (gnt_o != '0) begin
         if (gq.size() == 0) begin
            report("unexpected_gnt", $sformatf("gnt_o=%b, required no grant", gnt_o));
         end else begin
            g = gq.pop_front();
            check("gnt_onehot", 32'(gnt_o), 32'(4'b0001 << g.id));
            check("gnt_en", 32'(en_o), 32'd1);
            check("gnt_we", 32'(we_ob), 32'(g.we));
            check("gnt_addr", addr_ob, g.addr);
            check("gnt_din", din_ob, g.din);
            if (g.we == 4'h0) begin
               r.id = g.id; r.data = g.rdata; r.due = cyc + L;
               rq.push_back(r);
            end
         end
      end
      if (rq.size() > 0 && rq[0].due < cyc) begin
         r = rq.pop_front();
         report("missing_rvalid", $sformatf("rvalid_o=0, required id %0d at cycle %0d", r.id, r.due));
      end
      if (rvalid_o != '0) begin
         if (rq.size() == 0) begin
            report("unexpected_rvalid", $sformatf("rvalid_o=%b, required none", rvalid_o));
         end else begin
            r = rq.pop_front();
            check("rvalid_onehot", 32'(rvalid_o), 32'(4'b0001 << r.id));
            check("rvalid_data", dout_ob, r.data);
            check("rvalid_cycle", 32'(cyc), 32'(r.due));
         end
      end
      if (reset) rq.delete();
   end

   // One access: hold the request until granted, then drop it.
   task automatic do_access(input int k, input logic [3:0] we, input logic [31:0] addr,
                            input logic [31:0] din);
      bit got = 0;
      we_r[k] = we; addr_r[k] = addr; din_r[k] = din; req_r[k] = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (gnt_o[k]) begin got = 1; break; end
      end
      req_r[k] = 1'b0;
      if (!got) report("access_timeout", $sformatf("requester %0d never granted", k));
   endtask

   // Continuous read request for n grants; successive grants must be 2 cycles apart.
   task automatic do_burst(input int k, input logic [31:0] addr, input int n);
      int count = 0;
      int prev = 0;
      we_r[k] = 4'h0; addr_r[k] = addr; din_r[k] = 32'h0; req_r[k] = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (gnt_o[k]) begin
            if (count > 0) check("burst_gap", 32'(cyc - prev), 32'd2);
            prev = cyc;
            count++;
            if (count == n) break;
         end
      end
      req_r[k] = 1'b0;
      if (count < n) report("burst_timeout", $sformatf("requester %0d got %0d of %0d grants", k, count, n));
   endtask

   // All four request reads at once; expected order 0,1,2,3.
   task automatic rr_all();
      push_exp(0, 4'h0, 32'h0, 32'h0, 32'h11111111);
      push_exp(1, 4'h0, 32'h4, 32'h0, 32'h22222222);
      push_exp(2, 4'h0, 32'h8, 32'h0, 32'h33333333);
      push_exp(3, 4'h0, 32'hC, 32'h0, 32'h44444444);
      fork
         do_access(0, 4'h0, 32'h0, 32'h0);
         do_access(1, 4'h0, 32'h4, 32'h0);
         do_access(2, 4'h0, 32'h8, 32'h0);
         do_access(3, 4'h0, 32'hC, 32'h0);
      join
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < NREQ; k++) begin
         req_r[k] = 1'b0; we_r[k] = 4'h0; addr_r[k] = 32'h0; din_r[k] = 32'h0;
      end
      reset = 1'b1;

      // Reset with random requests: outputs stay quiet.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("reset_gnt", 32'(gnt_o), 32'h0);
         check("reset_en", 32'(en_o), 32'h0);
         check("reset_rvalid", 32'(rvalid_o), 32'h0);
         for (int k = 0; k < NREQ; k++) req_r[k] = 1'($urandom_range(0, 1));
      end
      for (int k = 0; k < NREQ; k++) req_r[k] = 1'b0;
      reset = 1'b0;

      // Round robin twice from reset.
      rr_all();
      rr_all();

      // Single continuous requester.
      repeat (4) push_exp(2, 4'h0, 32'h8, 32'h0, 32'h33333333);
      do_burst(2, 32'h8, 4);

      // Write then read back from another requester.
      push_exp(1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0);
      do_access(1, 4'hF, 32'h10, 32'hDEADBEEF);
      push_exp(3, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF);
      do_access(3, 4'h0, 32'h10, 32'h0);

      // Interleaved reads: back-to-back en_o, grants 0,1,0,1.
      repeat (4) @(posedge clk);
      #1;
      push_exp(0, 4'h0, 32'h0, 32'h0, 32'h11111111);
      push_exp(1, 4'h0, 32'h4, 32'h0, 32'h22222222);
      push_exp(0, 4'h0, 32'h0, 32'h0, 32'h11111111);
      push_exp(1, 4'h0, 32'h4, 32'h0, 32'h22222222);
      fork
         do_burst(0, 32'h0, 2);
         do_burst(1, 32'h4, 2);
         begin
            repeat (4) begin
               @(posedge clk); #1;
               check("b2b_en", 32'(en_o), 32'd1);
            end
         end
      join
      repeat (6) @(posedge clk);
      #1;

      // Mid-operation reset right after two reads issue.
      push_exp(0, 4'h0, 32'h0, 32'h0, 32'h11111111);
      push_exp(1, 4'h0, 32'h4, 32'h0, 32'h22222222);
      fork
         do_access(0, 4'h0, 32'h0, 32'h0);
         do_access(1, 4'h0, 32'h4, 32'h0);
      join
      reset = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         check("midrst_rvalid", 32'(rvalid_o), 32'h0);
      end
      reset = 1'b0;
      repeat (2 * L - 2) begin
         @(posedge clk); #1;
         check("midrst_rvalid", 32'(rvalid_o), 32'h0);
      end
      rr_all();

      repeat (10) @(posedge clk);
      #1;
      check("gnt_queue_drained", 32'(gq.size()), 32'h0);
      check("rvalid_queue_drained", 32'(rq.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
